// File: rtl/mw_writeback_arbiter.sv
// Write-back stage arbiter: drives the register-file write port from the MEM/WB
// instruction, filling idle slots with buffered late multdiv results.
module mw_writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_IR,
    input  logic [31:0] data_in_O,
    input  logic [31:0] data_in_D,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        stall_pipe
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic        dec_we;
    logic [4:0]  dec_addr;
    logic        dec_sel_d;
    logic        pw;
    logic [31:0] pw_data;

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [DEPTH-1:0] dead_reg;
    logic [DEPTH-1:0] kill_hit;
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   wr_ptr_next, rd_ptr_next;
    logic [AW:0]   count_next;
    logic [AW-1:0] wr_idx, head_idx;
    logic          empty;
    logic          push, pop;
    logic          md_ready_reg;
    logic [SW-1:0] starve_reg;

    logic unused_ir;
    assign unused_ir = ^{in_IR[21:7], in_IR[1:0]};

    assign opcode = in_IR[31:27];
    assign alu_op = in_IR[6:2];

    always_comb begin
        dec_we    = 1'b0;
        dec_addr  = in_IR[26:22];
        dec_sel_d = 1'b0;
        case (opcode)
            5'b00000: dec_we = (alu_op != 5'b00110) && (alu_op != 5'b00111);
            5'b00101: dec_we = 1'b1;
            5'b01000: begin
                dec_we    = 1'b1;
                dec_sel_d = 1'b1;
            end
            5'b00011: begin
                dec_we   = 1'b1;
                dec_addr = 5'd31;
            end
            5'b10101: begin
                dec_we   = 1'b1;
                dec_addr = 5'd30;
            end
            default: dec_we = 1'b0;
        endcase
        if (dec_addr == 5'd0)
            dec_we = 1'b0;
    end

    assign wr_idx   = wr_ptr_reg[AW-1:0];
    assign head_idx = rd_ptr_reg[AW-1:0];
    assign empty    = (wr_ptr_reg == rd_ptr_reg);

    assign stall_pipe = !empty && (starve_reg == LIMIT_C);
    // Reset gates the pipeline path so nothing is written while reset is held.
    assign pw      = dec_we && !stall_pipe && reset;
    assign pw_data = dec_sel_d ? data_in_D : data_in_O;

    assign pop  = !empty && !pw;
    assign push = md_valid && md_ready_reg && (md_rd != 5'd0) && !(pw && (md_rd == dec_addr));

    assign wr_ptr_next = wr_ptr_reg + (AW + 1)'(push);
    assign rd_ptr_next = rd_ptr_reg + (AW + 1)'(pop);
    assign count_next  = wr_ptr_next - rd_ptr_next;

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (pw) begin
            rf_we   = 1'b1;
            rf_addr = dec_addr;
            rf_data = pw_data;
        end else if (pop && !dead_reg[head_idx]) begin
            rf_we   = 1'b1;
            rf_addr = rd_mem[head_idx];
            rf_data = data_mem[head_idx];
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
            assign kill_hit[gi] = pw && (rd_mem[gi] == dec_addr);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_idx]   <= md_rd;
            data_mem[wr_idx] <= md_data;
        end
    end

    // A fresh push clears the slot's dead flag; a pipeline write to the same rd kills it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dead_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (wr_idx == AW'(i)))
                    dead_reg[i] <= 1'b0;
                else if (kill_hit[i])
                    dead_reg[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            md_ready_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            md_ready_reg <= (count_next != DEPTH_C);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_reg <= '0;
        else if (empty || pop)
            starve_reg <= '0;
        else if (starve_reg != LIMIT_C)
            starve_reg <= starve_reg + 1'b1;
    end

    assign md_ready = md_ready_reg;
endmodule

// File: tb/tb_mw_writeback_arbiter.sv
// Directed bench for mw_writeback_arbiter: decode, FIFO drain, starvation stall,
// WAW kill and mid-operation reset.
module tb_mw_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_IR;
    logic [31:0] data_in_O;
    logic [31:0] data_in_D;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        stall_pipe;

    int total  = 0;
    int passed = 0;

    mw_writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .in_IR(in_IR), .data_in_O(data_in_O),
        .data_in_D(data_in_D), .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data),
        .md_ready(md_ready), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .stall_pipe(stall_pipe)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] i_type(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'd0};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] alu);
        return {5'd0, rd, 15'd0, alu, 2'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, 32'(rf_we), 32'(we));
        chk({tag, ".addr"}, 32'(rf_addr), 32'(a));
        chk({tag, ".data"}, rf_data, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_IR = 32'd0; data_in_O = 32'd0; data_in_D = 32'd0;
        md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
        #2;
        port("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.stall", 32'(stall_pipe), 32'd0);
        chk("reset.ready", 32'(md_ready), 32'd0);

        // lw $5 right after release
        tick();
        reset = 1'b1;
        in_IR = i_type(5'b01000, 5'd5); data_in_O = 32'h10; data_in_D = 32'hDEADBEEF;
        #2;
        port("lw5", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("lw5.ready_pre", 32'(md_ready), 32'd0);
        tick();
        chk("ready_post", 32'(md_ready), 32'd1);

        // no-write decodes
        in_IR = i_type(5'b00101, 5'd0); data_in_O = 32'd7; #2;
        port("addi0", 1'b0, 5'd0, 32'd0);
        tick(); in_IR = i_type(5'b00010, 5'd3); #2;
        port("bne", 1'b0, 5'd0, 32'd0);
        tick(); in_IR = r_type(5'd4, 5'b00110); #2;
        port("mul4", 1'b0, 5'd0, 32'd0);
        tick(); in_IR = r_type(5'd4, 5'b00111); #2;
        port("div4", 1'b0, 5'd0, 32'd0);
        // writing decodes
        tick(); in_IR = r_type(5'd4, 5'b00000); data_in_O = 32'h44; #2;
        port("add4", 1'b1, 5'd4, 32'h44);
        tick(); in_IR = i_type(5'b00011, 5'd2); data_in_O = 32'h100; #2;
        port("jal", 1'b1, 5'd31, 32'h100);
        tick(); in_IR = i_type(5'b10101, 5'd2); data_in_O = 32'h3; #2;
        port("setx", 1'b1, 5'd30, 32'h3);

        // idle slot drain
        tick(); in_IR = 32'd0; md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h1234; #2;
        port("md9.push", 1'b0, 5'd0, 32'd0);
        tick(); md_valid = 1'b0; #2;
        port("md9.drain", 1'b1, 5'd9, 32'h1234);
        tick(); #2;
        port("md9.empty", 1'b0, 5'd0, 32'd0);

        // starvation stall under continuous addi $1
        in_IR = i_type(5'b00101, 5'd1); data_in_O = 32'h11;
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h333; #2;
        port("st.c0", 1'b1, 5'd1, 32'h11);
        tick(); md_rd = 5'd4; md_data = 32'h444; #2;
        chk("st.c1.ready", 32'(md_ready), 32'd1);
        tick(); md_valid = 1'b0; #2;
        chk("st.c2.ready", 32'(md_ready), 32'd0);
        chk("st.c2.stall", 32'(stall_pipe), 32'd0);
        tick(); #2; chk("st.c3.stall", 32'(stall_pipe), 32'd0);
        tick(); #2; chk("st.c4.stall", 32'(stall_pipe), 32'd0);
        tick(); #2;
        chk("st.c5.stall", 32'(stall_pipe), 32'd1);
        port("st.c5", 1'b1, 5'd3, 32'h333);
        tick(); #2;
        chk("st.c6.stall", 32'(stall_pipe), 32'd0);
        port("st.c6", 1'b1, 5'd1, 32'h11);
        chk("st.c6.ready", 32'(md_ready), 32'd1);
        tick(); in_IR = 32'd0; #2;
        port("st.c7", 1'b1, 5'd4, 32'h444);
        tick(); #2;
        port("st.c8", 1'b0, 5'd0, 32'd0);

        // WAW kill of a queued entry
        in_IR = i_type(5'b00101, 5'd1); data_in_O = 32'h11;
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hAA;
        tick(); md_valid = 1'b0; in_IR = i_type(5'b00101, 5'd7); data_in_O = 32'h55; #2;
        port("waw.pipe", 1'b1, 5'd7, 32'h55);
        tick(); in_IR = 32'd0; #2;
        port("waw.deadpop", 1'b0, 5'd0, 32'd0);
        tick(); #2;
        port("waw.after", 1'b0, 5'd0, 32'd0);

        // same-cycle kill and rd=0 are accepted but discarded
        in_IR = i_type(5'b00101, 5'd8); data_in_O = 32'h88;
        md_valid = 1'b1; md_rd = 5'd8; md_data = 32'hBB;
        tick(); in_IR = 32'd0; md_rd = 5'd0; md_data = 32'hCC; #2;
        port("disc.rd8", 1'b0, 5'd0, 32'd0);
        tick(); md_valid = 1'b0; #2;
        port("disc.rd0", 1'b0, 5'd0, 32'd0);
        chk("disc.ready", 32'(md_ready), 32'd1);

        // reset with two entries queued
        in_IR = i_type(5'b00101, 5'd1); data_in_O = 32'h11;
        md_valid = 1'b1; md_rd = 5'd10; md_data = 32'hA0;
        tick(); md_rd = 5'd11; md_data = 32'hB0;
        tick(); md_valid = 1'b0; reset = 1'b0; #1;
        port("rst.mid", 1'b0, 5'd0, 32'd0);
        chk("rst.mid.stall", 32'(stall_pipe), 32'd0);
        chk("rst.mid.ready", 32'(md_ready), 32'd0);
        tick(); reset = 1'b1; in_IR = 32'd0; #2;
        port("rst.rel0", 1'b0, 5'd0, 32'd0);
        chk("rst.rel0.ready", 32'(md_ready), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick(); #2;
            port($sformatf("rst.rel%0d", k), 1'b0, 5'd0, 32'd0);
        end
        chk("rst.ready_post", 32'(md_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mw_writeback_arbiter.md
Name: mw_writeback_arbiter

Overview:
- Consumer end of the MEM/WB pipeline register.
- Decodes the latched instruction word, selects the ALU result (O) or memory data (D), and drives the register-file write port.
- Also accepts late multdiv results through a valid/ready handshake. These are buffered in a small FIFO and drained into write-port slots the pipeline leaves idle.
- A starvation counter forces a pipeline stall so buffered results cannot wait indefinitely.

Parameters:
- DEPTH, 2, multdiv result FIFO entries (power of two, >=2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO may go without a pop before stall_pipe asserts

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous reset, active-low
- in_IR  in  32  instruction word from MEM/WB register
- data_in_O  in  32  ALU/PC+1/T result from MEM/WB register
- data_in_D  in  32  memory load data from MEM/WB register
- md_valid  in  1  multdiv result available
- md_rd  in  5  multdiv destination register
- md_data  in  32  multdiv result
- md_ready  out  1  FIFO can accept (registered, = !full)
- rf_we  out  1  register-file write enable
- rf_addr  out  5  register-file write address
- rf_data  out  32  register-file write data
- stall_pipe  out  1  pipeline must hold MEM/WB and upstream this cycle

Behaviour:
- Decode (combinational, from opcode in_IR[31:27], rd in_IR[26:22]):
  - 00000 R-type: write rd with O, except ALU op in_IR[6:2] = 00110 (mul) or 00111 (div), which are no-write here.
  - 00101 addi: rd <- O.
  - 01000 lw: rd <- D.
  - 00011 jal: $31 <- O.
  - 10101 setx: $30 <- O.
  - All other opcodes: no write.
  - Any target of $0: no write.
- Pipeline write (pw) = decoded write && !stall_pipe.
- Port mux: if pw, then rf_we=1 and addr/data come from the pipeline. Otherwise, if FIFO head is valid, rf_we=1 with the head's rd/data and the head is popped at the clock edge. Otherwise rf_we=0, rf_addr=0, rf_data=0.
- Write port is same-cycle combinational; the register file latches on the edge.
- FIFO:
  - Push on md_valid && md_ready. An entry pushed this cycle is not visible at the head until the next cycle (no bypass).
  - md_ready is registered: it is low on the cycle after the FIFO becomes full, even if a pop occurs that cycle.
  - md_valid with md_rd = 0 is accepted and discarded (no push).
- WAW kill:
  - When pw targets register X, every queued entry with rd = X is marked dead.
  - An md_valid arriving the same cycle with md_rd = X is accepted but discarded.
  - Dead entries pop silently: the cycle is consumed, rf_we=0 for the entry, and the pop still counts as a pop for starve_cnt.
- Starvation counter starve_cnt:
  - Clears when the FIFO is empty or a pop occurs.
  - Otherwise increments, saturating at STARVE_LIMIT.
- stall_pipe = FIFO non-empty && starve_cnt == STARVE_LIMIT. While high, the pipeline write is suppressed, the head pops, and the pipeline must hold the MEM/WB contents so the instruction is retired next cycle.
- Reset (reset=0, asynchronous):
  - FIFO emptied, pointers cleared, starve_cnt=0.
  - md_ready=0 while asserted; md_ready=1 on the first edge after release.
  - rf_we=0, rf_addr=0, rf_data=0, stall_pipe=0.
  - An entry in flight mid-operation is lost; no write occurs.

Test Plan:
- Reset then lw $5 with D=0xDEADBEEF, O=0x10 -> same cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; md_ready=1 after the first post-reset edge.
- addi $0 with O=7; then bne; then R-type mul to $4 -> rf_we=0 on all three cycles.
- md_valid rd=9 data=0x1234 while IR stream is all nops -> next cycle rf_we=1, addr=9, data=0x1234; FIFO empty after.
- Push rd=3 and rd=4 during continuous addi $1 writes -> md_ready=0 after the second push. stall_pipe=1 four cycles later; that cycle rf_addr=3, the addi is suppressed, and $1 is written the next cycle after the hold.
- Queue rd=7 data=0xAA, then pipeline addi $7 O=0x55 -> $7 written with 0x55; 0xAA is never written; the dead pop shows rf_we=0.
- Assert reset with two entries queued -> rf_we=0, stall_pipe=0, md_ready=0 immediately; after release no queued entry is ever written.
